// File: rtl/simd_result_drain.sv
// simd_result_drain: write-back drain buffer beside the SIMD lanes.
// Each rd_wr_en strobe captures {rd, lane_res_1..4} into a small FIFO. The head vector is
// serialised lane 1..4 onto one valid/ready stream. Strobes that arrive while the FIFO is
// full, with no pop in the same cycle, are dropped and flagged in a sticky overflow bit.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_wr_en, rd             capture strobe and destination register index
//   lane_res_1..lane_res_4   lane results captured on the strobe
//   out_ready                downstream accepts the current beat
//   out_valid/out_data/out_lane/out_rd/out_last   current beat
//   count, full, overflow    occupancy in vectors, full flag, sticky drop flag
module simd_result_drain #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_wr_en,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] lane_res_1,
    input  logic [DATA_W-1:0] lane_res_2,
    input  logic [DATA_W-1:0] lane_res_3,
    input  logic [DATA_W-1:0] lane_res_4,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_lane,
    output logic [4:0]        out_rd,
    output logic              out_last,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow
);

    typedef enum logic [0:0] {StEmpty, StStream} state_e;

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    state_e                       state_q, state_d;
    logic [ADDR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]                   lane_idx_q, lane_idx_d;
    logic [ADDR_W:0]              count_q, count_d;
    logic                         overflow_q, overflow_d;
    logic [3:0][DATA_W-1:0]       data_mem_q [DEPTH];
    logic [3:0][DATA_W-1:0]       data_mem_d [DEPTH];
    logic [4:0]                   rd_mem_q [DEPTH];
    logic [4:0]                   rd_mem_d [DEPTH];

    logic xfer, pop, capture;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == FullCount);
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        xfer    = out_valid && out_ready;
        pop     = xfer && (lane_idx_q == 2'd3);
        // A pop frees the head slot on the same edge, so a capture at full is still accepted.
        capture = rd_wr_en && (!full || pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (rd_wr_en & ~capture);
        data_mem_d = data_mem_q;
        rd_mem_d   = rd_mem_q;
        state_d    = state_q;
        lane_idx_d = lane_idx_q;

        if (capture) begin
            // When full, wr_ptr equals rd_ptr here; the head is being popped this same edge.
            data_mem_d[wr_ptr_q] = {lane_res_4, lane_res_3, lane_res_2, lane_res_1};
            rd_mem_d[wr_ptr_q]   = rd;
            wr_ptr_d             = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({capture, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            StEmpty: begin
                lane_idx_d = '0;
                if (capture) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (xfer) begin
                    lane_idx_d = pop ? 2'd0 : lane_idx_q + 2'd1;
                end
                if (count_d == '0) begin
                    state_d = StEmpty;
                end
            end
            default: begin
                state_d    = StEmpty;
                lane_idx_d = '0;
            end
        endcase
    end

    // Beat outputs are forced to zero whenever nothing is buffered.
    always_comb begin
        out_data = '0;
        out_lane = '0;
        out_rd   = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = data_mem_q[rd_ptr_q][lane_idx_q];
            out_lane = lane_idx_q;
            out_rd   = rd_mem_q[rd_ptr_q];
            out_last = (lane_idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lane_idx_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lane_idx_q <= lane_idx_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        data_mem_q <= data_mem_d;
        rd_mem_q   <= rd_mem_d;
    end

endmodule

// File: tb/tb_simd_result_drain.sv
module tb_simd_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_wr_en;
    logic [4:0]  rd;
    logic [15:0] lane_res_1, lane_res_2, lane_res_3, lane_res_4;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic [4:0]  out_rd;
    logic        out_last;
    logic [2:0]  count;
    logic        full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    simd_result_drain #(.DATA_W(16), .DEPTH(4), .ADDR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_wr_en   (rd_wr_en),
        .rd         (rd),
        .lane_res_1 (lane_res_1),
        .lane_res_2 (lane_res_2),
        .lane_res_3 (lane_res_3),
        .lane_res_4 (lane_res_4),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_rd     (out_rd),
        .out_last   (out_last),
        .count      (count),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard: vectors pushed when a strobe is driven and accepted, popped on the lane-4 beat.
    logic [4:0]  m_rd [$];
    logic [63:0] m_data [$];
    int          m_lane = 0;
    bit          m_ovf = 1'b0;
    logic [4:0]  got_rds [$];

    typedef struct {
        logic [4:0]  rd;
        logic [15:0] lanes [4];
        logic [4:0]  exp_rd;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_rd.delete();
        m_data.delete();
        m_lane = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [15:0] ed;
        logic [4:0]  er;
        logic [63:0] word;
        ev = (m_rd.size() != 0);
        ed = '0;
        er = '0;
        if (ev) begin
            word = m_data[0];
            ed   = word[16*m_lane +: 16];
            er   = m_rd[0];
        end
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_data",  32'(out_data),  32'(ed));
        chk("out_lane",  32'(out_lane),  ev ? 32'(m_lane) : 32'd0);
        chk("out_rd",    32'(out_rd),    32'(er));
        chk("out_last",  32'(out_last),  32'(ev && m_lane == 3));
        chk("count",     32'(count),     32'(m_rd.size()));
        chk("full",      32'(full),      32'(m_rd.size() == 4));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        if (out_valid && out_ready && out_last) got_rds.push_back(out_rd);
    endtask

    task automatic model_update();
        bit v, xfer, pop, cap;
        if (rst) begin
            model_clear();
            return;
        end
        v    = (m_rd.size() != 0);
        xfer = v && out_ready;
        pop  = xfer && (m_lane == 3);
        cap  = rd_wr_en && ((m_rd.size() < 4) || pop);
        if (rd_wr_en && !cap) m_ovf = 1'b1;
        if (xfer) begin
            if (pop) begin
                void'(m_rd.pop_front());
                void'(m_data.pop_front());
                m_lane = 0;
            end else begin
                m_lane++;
            end
        end
        if (cap) begin
            m_rd.push_back(rd);
            m_data.push_back({lane_res_4, lane_res_3, lane_res_2, lane_res_1});
        end
    endtask

    // One clock: inputs already driven; check at negedge, advance model at posedge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_vec(input logic [4:0] r, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        rd = r; lane_res_1 = a; lane_res_2 = b; lane_res_3 = c; lane_res_4 = d;
    endtask

    task automatic strobe(input logic [4:0] r, input logic [15:0] base);
        set_vec(r, base, base + 16'd1, base + 16'd2, base + 16'd3);
        rd_wr_en = 1'b1;
        cycle();
        rd_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_wr_en = 1'b0; out_ready = 1'b0;
        set_vec(5'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        #2;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset count",     32'(count),     32'd0);
        chk("reset overflow",  32'(overflow),  32'd0);
        do_reset();

        // T1: single vector, one-cycle latency, four beats.
        out_ready = 1'b1;
        set_vec(5'd5, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        rd_wr_en = 1'b1;
        cycle();
        rd_wr_en = 1'b0;
        chk("t1 valid next cycle", 32'(out_valid), 32'd1);
        chk("t1 first data",       32'(out_data),  32'h1111);
        chk("t1 out_rd",           32'(out_rd),    32'd5);
        repeat (6) cycle();
        chk("t1 count drained", 32'(count), 32'd0);

        // T2: backpressure holds beat 0 for three cycles.
        out_ready = 1'b0;
        set_vec(5'd7, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        rd_wr_en = 1'b1;
        cycle();
        rd_wr_en = 1'b0;
        repeat (3) cycle();
        chk("t2 held data", 32'(out_data), 32'h1111);
        chk("t2 held lane", 32'(out_lane), 32'd0);
        out_ready = 1'b1;
        repeat (6) cycle();
        chk("t2 count drained", 32'(count), 32'd0);

        // T3: fill, drop the fifth strobe.
        got_rds.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) strobe(5'(i), 16'(i * 16'h0100));
        chk("t3 count",    32'(count),    32'd4);
        chk("t3 full",     32'(full),     32'd1);
        chk("t3 overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        repeat (18) cycle();
        chk("t3 vectors drained", 32'(got_rds.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_rds.size(); i++) chk("t3 rd order", 32'(got_rds[i]), 32'(i + 1));

        // T4: capture in the same cycle as the head's lane-4 transfer at full.
        do_reset();
        got_rds.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) strobe(5'(i), 16'(i * 16'h1000));
        out_ready = 1'b1;
        repeat (3) cycle();
        strobe(5'd9, 16'h9000);
        chk("t4 count", 32'(count), 32'd4);
        chk("t4 overflow", 32'(overflow), 32'd0);
        repeat (20) cycle();
        chk("t4 vectors drained", 32'(got_rds.size()), 32'd5);
        if (got_rds.size() == 5) chk("t4 last rd", 32'(got_rds[4]), 32'd9);

        // T5: asynchronous reset in the middle of a drain.
        out_ready = 1'b0;
        strobe(5'd2, 16'h2000);
        strobe(5'd3, 16'h3000);
        out_ready = 1'b1;
        repeat (2) cycle();
        rst = 1'b1;
        #1;
        model_clear();
        chk("t5 valid in reset", 32'(out_valid), 32'd0);
        chk("t5 count in reset", 32'(count),     32'd0);
        cycle();
        rst = 1'b0;
        out_ready = 1'b0;
        strobe(5'd4, 16'h4000);
        chk("t5 lane restart", 32'(out_lane), 32'd0);
        chk("t5 data restart", 32'(out_data), 32'h4000);
        out_ready = 1'b1;
        repeat (6) cycle();

        // T6: ten spaced vectors through the FIFO, pointers wrap.
        for (int i = 0; i < 10; i++) begin
            tbl[i].rd = 5'(i + 10);
            for (int l = 0; l < 4; l++) tbl[i].lanes[l] = 16'(16'hA000 + i * 16 + l);
            tbl[i].exp_rd = 5'(i + 10);
        end
        got_rds.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_vec(tbl[i].rd, tbl[i].lanes[0], tbl[i].lanes[1], tbl[i].lanes[2], tbl[i].lanes[3]);
            rd_wr_en = 1'b1;
            cycle();
            rd_wr_en = 1'b0;
            repeat (5) cycle();
        end
        repeat (4) cycle();
        chk("t6 vectors drained", 32'(got_rds.size()), 32'd10);
        for (int i = 0; i < 10 && i < got_rds.size(); i++) chk("t6 rd order", 32'(got_rds[i]), 32'(tbl[i].exp_rd));
        chk("t6 overflow", 32'(overflow), 32'd0);
        chk("t6 count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
